lsu_dmem: RTL and testbench
===========================

LSU_DMEM -- requirements
Module: lsu_dmem

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 4: consecutive dmem_wait-high cycles tolerated before a timeout fault.
REQ-002 SHALL have ports (all widths in bits):
- clk  in  1  single clock; all state on posedge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  pipeline request present
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V width/sign code
- req_address  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- req_rd  in  5  load destination tag
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  32  extended load data; 0 for stores/faults
- resp_rd  out  5  tag of the completing request
- resp_fault  out  1  illegal funct3 or timeout
- resp_misaligned  out  1  misalignment trap (REQ-015)
- dmem_address, dmem_write_data  out  32 each  to memory
- dmem_enable, dmem_read_enable, dmem_write_enable  out  1 each  to memory
- dmem_read_mode, dmem_write_mode  out  3 each  equal to funct3 of the issued request
- dmem_read_data  in  32  memory data, zero-extended, valid one cycle after issue when dmem_wait=0
- dmem_wait  in  1  memory splitting an unaligned access

Function
REQ-003 SHALL implement states IDLE, PEND, WAIT, FAULT.
REQ-004 SHALL assert req_ready in IDLE, and in PEND/WAIT only in the cycle dmem_wait=0; otherwise 0.
REQ-005 SHALL issue an accepted request in the acceptance cycle: dmem_enable=1, read_enable=!req_write, write_enable=req_write, modes=req_funct3, address/wdata passed through; then go PEND.
REQ-006 SHALL drive all dmem enables 0 in every cycle no request is issued, including every cycle dmem_wait=1.
REQ-007 In PEND/WAIT with dmem_wait=0: SHALL pulse resp_valid with the registered tag and return to IDLE, or go PEND if a new request is accepted that cycle; back-to-back issue gives one response per cycle.
REQ-008 In PEND with dmem_wait=1: SHALL go WAIT and set the wait counter to 1; each further WAIT cycle with dmem_wait=1 increments it.
REQ-009 When the counter reaches WAIT_LIMIT with dmem_wait still 1: SHALL pulse resp_valid with resp_fault=1 and resp_data=0, then go IDLE.
REQ-010 SHALL extend loads from dmem_read_data by the registered funct3:
- 000 sign-extend bit 7
- 001 sign-extend bit 15
- 010 pass through
- 100 zero-extend 8 bits
- 101 zero-extend 16 bits
REQ-011 SHALL accept illegal funct3 (011, 110, 111; also 100/101 with req_write=1) without issuing; go FAULT; next cycle pulse resp_valid with resp_fault=1; req_ready=0 while in FAULT.
REQ-012 SHALL drive resp_data, resp_fault and resp_misaligned to 0 whenever resp_valid=0.

Reset
REQ-013 On reset assertion, SHALL immediately enter IDLE, clear the counter, tag and funct3 registers, and force resp_valid=0, req_ready=0 and all dmem enables 0 while reset is high.
REQ-014 An operation cut by reset SHALL produce no response; the first request after release is accepted normally.

Configuration
REQ-015 With LSU_MISALIGN_TRAP_EN defined, SHALL not issue halfword requests with address[0]=1 or word requests with address[1:0]!=0; instead go FAULT and respond with resp_misaligned=1 and resp_data=0. Without the macro, SHALL issue them and rely on dmem_wait; resp_misaligned SHALL be constant 0.

Verification
REQ-016 Load funct3=000 at 0x8000_0003, memory word 0x80FF_FF7F, returns 0x0000_0080 -> resp_data=0xFFFF_FF80 one cycle after accept, dmem_wait=0.
REQ-017 Load funct3=101 at 0x8000_0002 -> dmem_read_data 0x0000_8001 -> resp_data=0x0000_8001.
REQ-018 Word load at 0x8000_0001, macro off; memory asserts dmem_wait for 1 cycle -> req_ready=0 and enables 0 that cycle; resp_valid 2 cycles after accept with returned data.
REQ-019 Same load with macro on -> no dmem_enable; next cycle resp_valid=1, resp_misaligned=1, resp_data=0.
REQ-020 dmem_wait held high -> resp_fault at the 4th wait cycle; then reset mid-PEND -> req_ready=0 and no resp_valid.
REQ-021 Three back-to-back loads, no wait -> three consecutive resp_valid pulses with tags in order; funct3=011 -> resp_fault=1, no dmem_enable.

Source files
------------

// File: rtl/lsu_dmem.sv
// ----------------------------------------------------------------------------
// lsu_dmem -- load/store unit front end for a RISC-V style data memory port.
//
// Takes one request at a time from the pipeline, issues it to the data memory
// in the acceptance cycle and produces one completion pulse per request. Loads
// are sign/zero-extended according to the registered funct3. Illegal funct3
// codes are accepted but not issued and complete one cycle later with a fault.
// A memory that holds dmem_wait high for WAIT_LIMIT consecutive cycles causes
// a timeout fault.
//
// Optional feature (macro LSU_MISALIGN_TRAP_EN):
//   defined   : misaligned halfword/word requests are not issued; they
//               complete one cycle later with resp_misaligned=1.
//   undefined : misaligned requests are issued and the memory splits them
//               (using dmem_wait); resp_misaligned is tied to 0.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_*                 pipeline request (valid/ready handshake)
//   resp_*                one-cycle completion pulse with tag, data, status
//   dmem_*                memory command outputs / read data + wait inputs
//   dbg_state             current FSM state (IDLE=0, PEND=1, WAIT=2, FAULT=3)
//
// Handshake: a request transfers in a cycle where req_valid && req_ready.
// req_ready is purely combinational from state and dmem_wait; req_valid must
// not depend on req_ready. resp_valid is a single-cycle pulse with no ready.
// ----------------------------------------------------------------------------
module lsu_dmem #(
    parameter int WAIT_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_fault,
    output logic        resp_misaligned,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_write_data,
    output logic        dmem_enable,
    output logic        dmem_read_enable,
    output logic        dmem_write_enable,
    output logic [2:0]  dmem_read_mode,
    output logic [2:0]  dmem_write_mode,
    input  logic [31:0] dmem_read_data,
    input  logic        dmem_wait,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_WAIT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic            r_write;
    logic            r_misal;

    logic            w_busy;
    logic            w_ready_raw;
    logic            w_accept;
    logic            w_illegal;
    logic            w_misal;
    logic            w_issue;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_timeout;
    logic [31:0]     w_load_ext;
    logic            w_resp_misal;

    assign dbg_state = r_state;

    // PEND and WAIT both have an access outstanding at the memory.
    assign w_busy      = (r_state == S_PEND) || (r_state == S_WAIT);
    assign w_ready_raw = (r_state == S_IDLE) || (w_busy && !dmem_wait);
    assign req_ready   = !reset && w_ready_raw;
    assign w_accept    = req_valid && req_ready;

    // Byte/halfword-unsigned codes only exist for loads.
    always_comb begin
        w_illegal = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            3'b100, 3'b101:         w_illegal = req_write;
            default:                w_illegal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // An illegal code takes priority, so misalignment is only flagged for
    // otherwise legal requests.
    assign w_misal = !w_illegal &&
                     (((req_funct3[1:0] == 2'b01) && req_address[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_address[1:0] != 2'b00)));
`else
    assign w_misal = 1'b0;
`endif

    assign w_issue = w_accept && !w_illegal && !w_misal;

    // The first stalled cycle (in PEND) counts as wait cycle 1.
    assign w_cnt_inc = (r_state == S_PEND) ? CW'(1) : (r_cnt + CW'(1));
    assign w_timeout = w_busy && dmem_wait && (w_cnt_inc >= LIMIT);

    always_comb begin
        w_load_ext = 32'd0;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{dmem_read_data[7]}},  dmem_read_data[7:0]};
            3'b001:  w_load_ext = {{16{dmem_read_data[15]}}, dmem_read_data[15:0]};
            3'b010:  w_load_ext = dmem_read_data;
            3'b100:  w_load_ext = {24'd0, dmem_read_data[7:0]};
            3'b101:  w_load_ext = {16'd0, dmem_read_data[15:0]};
            default: w_load_ext = 32'd0;
        endcase
    end

    always_comb begin
        w_state_next      = r_state;
        resp_valid        = 1'b0;
        resp_data         = 32'd0;
        resp_fault        = 1'b0;
        w_resp_misal      = 1'b0;
        dmem_enable       = 1'b0;
        dmem_read_enable  = 1'b0;
        dmem_write_enable = 1'b0;
        dmem_read_mode    = 3'd0;
        dmem_write_mode   = 3'd0;
        dmem_address      = 32'd0;
        dmem_write_data   = 32'd0;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_IDLE;
            end
            S_PEND, S_WAIT: begin
                if (!dmem_wait) begin
                    resp_valid   = 1'b1;
                    resp_data    = r_write ? 32'd0 : w_load_ext;
                    w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    resp_valid   = 1'b1;
                    resp_fault   = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_FAULT: begin
                resp_valid   = 1'b1;
                resp_fault   = !r_misal;
                w_resp_misal = r_misal;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase

        // A new acceptance overrides the return to IDLE (back-to-back issue).
        if (w_accept) begin
            w_state_next = w_issue ? S_PEND : S_FAULT;
        end

        if (w_issue) begin
            dmem_enable       = 1'b1;
            dmem_read_enable  = !req_write;
            dmem_write_enable = req_write;
            dmem_read_mode    = req_funct3;
            dmem_write_mode   = req_funct3;
            dmem_address      = req_address;
            dmem_write_data   = req_wdata;
        end

        // Reset silences every output immediately, not just at the next edge.
        if (reset) begin
            resp_valid        = 1'b0;
            resp_data         = 32'd0;
            resp_fault        = 1'b0;
            w_resp_misal      = 1'b0;
            dmem_enable       = 1'b0;
            dmem_read_enable  = 1'b0;
            dmem_write_enable = 1'b0;
        end
    end

    assign resp_rd = resp_valid ? r_rd : 5'd0;

`ifdef LSU_MISALIGN_TRAP_EN
    assign resp_misaligned = w_resp_misal;
`else
    assign resp_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_busy && dmem_wait && !w_timeout) begin
            r_cnt <= w_cnt_inc;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd     <= 5'd0;
            r_funct3 <= 3'd0;
            r_write  <= 1'b0;
            r_misal  <= 1'b0;
        end else if (w_accept) begin
            r_rd     <= req_rd;
            r_funct3 <= req_funct3;
            r_write  <= req_write;
            r_misal  <= w_misal;
        end
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// ----------------------------------------------------------------------------
// tb_lsu_dmem -- self-checking bench for lsu_dmem.
// Each cycle the bench drives inputs just after the rising edge and compares
// all outputs on the falling edge against a transaction-level reference
// model (a queue of outstanding requests plus a stall counter).
// ----------------------------------------------------------------------------
module tb_lsu_dmem;

    localparam int WAIT_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_fault;
    logic        resp_misaligned;
    logic [31:0] dmem_address;
    logic [31:0] dmem_write_data;
    logic        dmem_enable;
    logic        dmem_read_enable;
    logic        dmem_write_enable;
    logic [2:0]  dmem_read_mode;
    logic [2:0]  dmem_write_mode;
    logic [31:0] dmem_read_data;
    logic        dmem_wait;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    lsu_dmem #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_funct3        (req_funct3),
        .req_address       (req_address),
        .req_wdata         (req_wdata),
        .req_rd            (req_rd),
        .resp_valid        (resp_valid),
        .resp_data         (resp_data),
        .resp_rd           (resp_rd),
        .resp_fault        (resp_fault),
        .resp_misaligned   (resp_misaligned),
        .dmem_address      (dmem_address),
        .dmem_write_data   (dmem_write_data),
        .dmem_enable       (dmem_enable),
        .dmem_read_enable  (dmem_read_enable),
        .dmem_write_enable (dmem_write_enable),
        .dmem_read_mode    (dmem_read_mode),
        .dmem_write_mode   (dmem_write_mode),
        .dmem_read_data    (dmem_read_data),
        .dmem_wait         (dmem_wait),
        .dbg_state         (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic       write;
        logic [2:0] f3;
        logic [4:0] rd;
        logic       bad_ill;
        logic       bad_mis;
    } txn_t;

    txn_t pend_q[$];
    int   waits = 0;

    function automatic logic is_illegal(input logic w, input logic [2:0] f3);
        int code = int'(f3);
        if (code == 3 || code == 6 || code == 7) return 1'b1;
        if (w && (code == 4 || code == 5)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic is_misal(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        int size = 1 << (int'(f3) % 4);
        return (size > 1) && ((a % size) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] b = d & 32'h0000_00FF;
        logic [31:0] h = d & 32'h0000_FFFF;
        case (int'(f3))
            0: return (b >= 32'h80)   ? b + 32'hFFFF_FF00 : b;
            1: return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            2: return d;
            4: return b;
            5: return h;
            default: return 32'd0;
        endcase
    endfunction

    // One clock cycle: drive inputs, then check every output against the model.
    task automatic step(input logic v, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input logic dw, input logic [31:0] rdat);
        txn_t t;
        txn_t n;
        logic exp_rdy, exp_rv, exp_flt, exp_mis, acc, ill, mis;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        @(posedge clk); #1;
        req_valid = v; req_write = w; req_funct3 = f3; req_address = a;
        req_wdata = wd; req_rd = rd; dmem_wait = dw; dmem_read_data = rdat;
        @(negedge clk);
        exp_rdy = 1'b1; exp_rv = 1'b0; exp_flt = 1'b0; exp_mis = 1'b0;
        exp_data = 32'd0; exp_rd = 5'd0;
        if (pend_q.size() != 0) begin
            t = pend_q[0];
            exp_rd = t.rd;
            if (t.bad_ill || t.bad_mis) begin
                exp_rv = 1'b1; exp_flt = t.bad_ill; exp_mis = t.bad_mis; exp_rdy = 1'b0;
                void'(pend_q.pop_front());
            end else if (!dw) begin
                exp_rv = 1'b1;
                exp_data = t.write ? 32'd0 : extend(t.f3, rdat);
                void'(pend_q.pop_front());
                waits = 0;
            end else begin
                exp_rdy = 1'b0;
                waits++;
                if (waits >= WAIT_LIMIT) begin
                    exp_rv = 1'b1; exp_flt = 1'b1;
                    void'(pend_q.pop_front());
                    waits = 0;
                end
            end
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("resp_valid", 32'(resp_valid), 32'(exp_rv));
        check("resp_data", resp_data, exp_data);
        check("resp_fault", 32'(resp_fault), 32'(exp_flt));
        check("resp_misaligned", 32'(resp_misaligned), 32'(exp_mis));
        if (exp_rv) check("resp_rd", 32'(resp_rd), 32'(exp_rd));

        acc = v && exp_rdy;
        ill = is_illegal(w, f3);
        mis = !ill && is_misal(f3, a);
        if (acc) begin
            n.write = w; n.f3 = f3; n.rd = rd; n.bad_ill = ill; n.bad_mis = mis;
            pend_q.push_back(n);
            waits = 0;
        end
        if (acc && !ill && !mis) begin
            check("dmem_enable", 32'(dmem_enable), 32'd1);
            check("dmem_read_enable", 32'(dmem_read_enable), 32'(!w));
            check("dmem_write_enable", 32'(dmem_write_enable), 32'(w));
            check("dmem_address", dmem_address, a);
            check("dmem_write_data", dmem_write_data, wd);
            check("dmem_read_mode", 32'(dmem_read_mode), 32'(f3));
            check("dmem_write_mode", 32'(dmem_write_mode), 32'(f3));
        end else begin
            check("dmem_enable_idle", 32'(dmem_enable), 32'd0);
            check("dmem_read_enable_idle", 32'(dmem_read_enable), 32'd0);
            check("dmem_write_enable_idle", 32'(dmem_write_enable), 32'd0);
        end
    endtask

    task automatic idle_step(input logic dw, input logic [31:0] rdat);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, dw, rdat);
    endtask

    // Assert reset between clock edges, check outputs forced low, release.
    task automatic reset_mid();
        @(posedge clk); #2;
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2;
        req_address = 32'h100; dmem_wait = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_dmem_enable", 32'(dmem_enable), 32'd0);
        @(posedge clk); #1;
        check("rst_hold_req_ready", 32'(req_ready), 32'd0);
        check("rst_hold_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_hold_dmem_enable", 32'(dmem_enable), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0; req_valid = 1'b0;
        pend_q.delete();
        waits = 0;
    endtask

    initial begin
        int burst;
        logic v, w, dw;
        logic [2:0] f3;
        logic [31:0] a;
        logic [2:0] legal_ld[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_address = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        dmem_wait = 1'b0; dmem_read_data = 32'd0;
        #3;
        check("init_req_ready", 32'(req_ready), 32'd0);
        check("init_resp_valid", 32'(resp_valid), 32'd0);
        check("init_dmem_enable", 32'(dmem_enable), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Signed byte load: 0x80 -> 0xFFFFFF80.
        step(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'd0, 5'd1, 1'b0, 32'd0);
        idle_step(1'b0, 32'h0000_0080);
        check("lb_sign_const", resp_data, 32'hFFFF_FF80);

        // Unsigned halfword load.
        step(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'd0, 5'd2, 1'b0, 32'd0);
        idle_step(1'b0, 32'h0000_8001);
        check("lhu_const", resp_data, 32'h0000_8001);

        // Unaligned word load; memory stalls for one cycle where applicable.
        step(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'd0, 5'd3, 1'b0, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        idle_step(1'b0, 32'h1234_5678);
        check("misal_trap_const", 32'(resp_misaligned), 32'd1);
`else
        step(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 5'd9, 1'b1, 32'hDEAD_BEEF);
        idle_step(1'b0, 32'h1234_5678);
        check("lw_unaligned_const", resp_data, 32'h1234_5678);
`endif

        // Memory stalls indefinitely: timeout on the 4th wait cycle.
        step(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'd0, 5'd4, 1'b0, 32'd0);
        for (int i = 0; i < WAIT_LIMIT; i++) idle_step(1'b1, 32'd0);
        check("timeout_const", 32'(resp_fault), 32'd1);
        idle_step(1'b0, 32'd0);

        // Reset while a load is pending: no response afterwards.
        step(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'd0, 5'd5, 1'b0, 32'd0);
        reset_mid();
        idle_step(1'b0, 32'hAAAA_5555);
        check("post_reset_no_resp", 32'(resp_valid), 32'd0);

        // Three back-to-back loads, then an illegal funct3.
        step(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd11, 1'b0, 32'd0);
        step(1'b1, 1'b0, 3'b000, 32'h104, 32'd0, 5'd12, 1'b0, 32'h0000_00F0);
        step(1'b1, 1'b0, 3'b100, 32'h108, 32'd0, 5'd13, 1'b0, 32'h0000_00F1);
        idle_step(1'b0, 32'h0000_00F2);
        check("b2b_last_rd", 32'(resp_rd), 32'd13);
        step(1'b1, 1'b0, 3'b011, 32'h200, 32'd0, 5'd14, 1'b0, 32'd0);
        idle_step(1'b0, 32'd0);
        check("illegal_fault_const", 32'(resp_fault), 32'd1);

        // Randomized traffic.
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            v = ($urandom_range(0, 9) < 7);
            w = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 99) < 12) f3 = 3'($urandom_range(0, 7));
            else if (w) f3 = 3'($urandom_range(0, 2));
            else f3 = legal_ld[$urandom_range(0, 4)];
            a = $urandom();
            dw = 1'b0;
            // Memory only stalls while a real access is outstanding.
            if (pend_q.size() != 0 && !pend_q[0].bad_ill && !pend_q[0].bad_mis) begin
                if (burst > 0) begin
                    dw = 1'b1; burst--;
                end else if ($urandom_range(0, 9) < 2) begin
                    burst = $urandom_range(0, 5);
                    dw = 1'b1;
                end
            end else begin
                burst = 0;
            end
            step(v, w, f3, a, $urandom(), 5'($urandom_range(0, 31)), dw, $urandom());
            if (c == 2000) reset_mid();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
